uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 30 +++
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial line and received-word signals of the UART receiver.
// The master modport is the receiver side; the slave modport is its consumer.
interface uart_rx_if #(
  parameter int WIDTH = 8
);
  logic             rx_in;
  logic [WIDTH-1:0] uart_rx_out;
  logic             uart_rx_ready;
  logic             rx_busy;
  logic             frame_err;
  logic             parity_err;

  modport master (
    input  rx_in,
    output uart_rx_out,
    output uart_rx_ready,
    output rx_busy,
    output frame_err,
    output parity_err
  );

  modport slave (
    output rx_in,
    input  uart_rx_out,
    input  uart_rx_ready,
    input  rx_busy,
    input  frame_err,
    input  parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, LSB-first data.
// Define UART_RX_PARITY_EN to add one even-parity bit after the data bits.
module uart_rx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input logic       clk,
  input logic       rst,
  uart_rx_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic             rx_meta_p0;
  logic             rx_s;
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] data_out;
  logic             ready;
  logic             ferr;
  logic             wait_high;
  logic             tick_half;
  logic             tick_full;
  logic             last_bit;
  logic             stop_done;
  logic             par_ok;

  // Synchronizer stage: rx_in is asynchronous, only rx_s is used downstream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_meta_p0 <= bus.rx_in;
      rx_s       <= rx_meta_p0;
    end
  end

  assign tick_half = (cnt == HALF_LAST);
  assign tick_full = (cnt == FULL_LAST);
  assign last_bit  = (bit_idx == LAST_IDX);
  assign stop_done = (state == STOP) && tick_full;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic perr;

  // Data bits plus parity bit must hold an even number of ones
  assign par_ok         = ~^{shreg, par_bit};
  assign bus.parity_err = perr;
`else
  assign par_ok         = 1'b1;
  assign bus.parity_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // After a low stop bit the line must go high before a new start counts
        if (!wait_high && !rx_s) state_nxt = START;
      end
      START: begin
        if (tick_half) state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick_full && last_bit) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_full) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (tick_full) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame stage: bit timing, shifting and end-of-frame result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data_out  <= '0;
      ready     <= 1'b0;
      ferr      <= 1'b0;
      wait_high <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= 1'b0;
      ferr  <= 1'b0;

      if ((state_nxt != state) || (state == IDLE) || tick_full)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);

      if ((state == IDLE) && rx_s)
        wait_high <= 1'b0;

      if ((state == DATA) && tick_full) begin
        shreg   <= {rx_s, shreg[WIDTH-1:1]};
        bit_idx <= last_bit ? '0 : bit_idx + IDX_W'(1);
      end

      if (stop_done) begin
        if (rx_s && par_ok) begin
          data_out <= shreg;
          ready    <= 1'b1;
        end
        ferr      <= ~rx_s;
        wait_high <= ~rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bit <= 1'b0;
      perr    <= 1'b0;
    end else begin
      perr <= 1'b0;
      if ((state == PARITY) && tick_full)
        par_bit <= rx_s;
      if (stop_done)
        perr <= ~par_ok;
    end
  end
`endif

  assign bus.uart_rx_out   = data_out;
  assign bus.uart_rx_ready = ready;
  assign bus.frame_err     = ferr;
  assign bus.rx_busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames, glitch, reset abort, random frames.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int WIDTH = 8;
  localparam int CPB   = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Mid-stop-bit sample time after the falling start edge, plus one cycle
  localparam int LAT = (WIDTH + 1) * CPB + CPB / 2 + 3 + PAR * CPB;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_rx_if #(.WIDTH(WIDTH)) bus ();

  uart_rx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int n_ready = 0, n_ferr = 0, n_perr = 0, n_dbl = 0;
  int ready_cyc = 0, busy_fall_cyc = 0, fall_cyc = 0;
  logic [WIDTH-1:0] last_got = '0;
  logic prev_ready = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0, prev_busy = 1'b0;

  logic [WIDTH-1:0] exp_out = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.uart_rx_ready === 1'b1) begin
      n_ready++;
      ready_cyc = cyc;
      last_got  = bus.uart_rx_out;
    end
    if (bus.frame_err === 1'b1)  n_ferr++;
    if (bus.parity_err === 1'b1) n_perr++;
    if ((bus.uart_rx_ready === 1'b1 && prev_ready) ||
        (bus.frame_err === 1'b1 && prev_ferr) ||
        (bus.parity_err === 1'b1 && prev_perr))
      n_dbl++;
    if (prev_busy && bus.rx_busy === 1'b0) busy_fall_cyc = cyc;
    prev_ready = (bus.uart_rx_ready === 1'b1);
    prev_ferr  = (bus.frame_err === 1'b1);
    prev_perr  = (bus.parity_err === 1'b1);
    prev_busy  = (bus.rx_busy === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    bus.rx_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Sends one frame and checks its outcome against the frame-level rules.
  task automatic run_frame(input logic [WIDTH-1:0] d, input logic stop,
                           input logic par_flip, input int gap, input string tag);
    int r0, f0, p0;
    logic valid, exp_perr;
    r0 = n_ready; f0 = n_ferr; p0 = n_perr;
    exp_perr = (PAR == 1) && par_flip;
    valid    = stop && !exp_perr;

    bus.rx_in = 1'b0;
    fall_cyc  = cyc;
    drive_bit(1'b0);
    check({tag, "_busy_mid"}, 32'(bus.rx_busy), 32'd1);
    for (int i = 0; i < WIDTH; i++) drive_bit(d[i]);
    if (PAR == 1) drive_bit((^d) ^ par_flip);
    drive_bit(stop);

    if (valid) exp_out = d;
    check({tag, "_ready_cnt"}, 32'(n_ready - r0), 32'(valid));
    check({tag, "_ferr_cnt"},  32'(n_ferr - f0),  32'(!stop));
    check({tag, "_perr_cnt"},  32'(n_perr - p0),  32'(exp_perr));
    check({tag, "_out"},       32'(bus.uart_rx_out), 32'(exp_out));
    check({tag, "_busy_end"},  32'(bus.rx_busy), 32'd0);
    if (valid) begin
      check({tag, "_latency"},   32'(ready_cyc - fall_cyc), 32'(LAT));
      check({tag, "_busy_fall"}, 32'(busy_fall_cyc), 32'(ready_cyc));
      check({tag, "_got"},       32'(last_got), 32'(d));
    end
    for (int g = 0; g < gap; g++) drive_bit(1'b1);
  endtask

  initial begin
    int r0, f0, p0;
    logic [WIDTH-1:0] d;
    logic stp, flp;
    int gap;

    bus.rx_in = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out",   32'(bus.uart_rx_out),   32'd0);
    check("rst_ready", 32'(bus.uart_rx_ready), 32'd0);
    check("rst_busy",  32'(bus.rx_busy),       32'd0);
    check("rst_ferr",  32'(bus.frame_err),     32'd0);
    check("rst_perr",  32'(bus.parity_err),    32'd0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    run_frame(8'hA5, 1'b1, 1'b0, 1, "a5");

    // Short low glitch on an idle line
    r0 = n_ready; f0 = n_ferr; p0 = n_perr;
    bus.rx_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("glitch_busy_hi", 32'(bus.rx_busy), 32'd1);
    repeat (3 * CPB) @(posedge clk);
    #1;
    check("glitch_busy_lo", 32'(bus.rx_busy), 32'd0);
    check("glitch_pulses",  32'((n_ready - r0) + (n_ferr - f0) + (n_perr - p0)), 32'd0);
    check("glitch_out",     32'(bus.uart_rx_out), 32'(exp_out));

    run_frame(8'h3C, 1'b0, 1'b0, 1, "3c_stop_low");
    run_frame(8'h00, 1'b1, 1'b0, 0, "b2b_00");
    run_frame(8'hFF, 1'b1, 1'b0, 1, "b2b_ff");

    if (PAR == 1) begin
      run_frame(8'h01, 1'b1, 1'b1, 1, "par_bad");
      run_frame(8'h01, 1'b1, 1'b0, 1, "par_good");
      run_frame(8'h5A, 1'b0, 1'b1, 1, "par_both");
    end

    // Reset in the middle of the 4th data bit of 0x55
    r0 = n_ready; f0 = n_ferr; p0 = n_perr;
    d = 8'h55;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    bus.rx_in = d[3];
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_out",   32'(bus.uart_rx_out),   32'd0);
    check("mid_rst_ready", 32'(bus.uart_rx_ready), 32'd0);
    check("mid_rst_busy",  32'(bus.rx_busy),       32'd0);
    check("mid_rst_ferr",  32'(bus.frame_err),     32'd0);
    check("mid_rst_perr",  32'(bus.parity_err),    32'd0);
    exp_out = '0;
    bus.rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    check("mid_rst_pulses", 32'((n_ready - r0) + (n_ferr - f0) + (n_perr - p0)), 32'd0);
    check("mid_rst_idle",   32'(bus.rx_busy), 32'd0);
    run_frame(8'h81, 1'b1, 1'b0, 1, "after_rst_81");

    for (int k = 0; k < 16; k++) begin
      d   = WIDTH'($urandom);
      stp = ($urandom_range(0, 4) != 0);
      flp = (PAR == 1) && ($urandom_range(0, 3) == 0);
      gap = stp ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      run_frame(d, stp, flp, gap, "rand");
    end

    check("no_double_pulse", 32'(n_dbl), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
